// File: rtl/status_value_queue.sv
// status_value_queue: head-at-zero compacting queue with in-place update, flush and sticky errors
module status_value_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_value_i,
  input  logic                   pull_i,
  input  logic                   upd_i,
  input  logic [IDX_W-1:0]       upd_idx_i,
  input  logic [WIDTH-1:0]       upd_value_i,
  input  logic                   err_clr_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   head_valid_o,
  output logic [DEPTH*WIDTH-1:0] vector_o,
  output logic [DEPTH-1:0]       valid_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);
  logic [DEPTH-1:0][WIDTH-1:0] ent_q, ent_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, tgt;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic pull_ok, push_ok, upd_ok;
  assign pull_ok = pull_i && cnt_q != '0;
  assign push_ok = push_i && (cnt_q != CNT_W'(DEPTH) || pull_ok);
  assign upd_ok  = upd_i && CNT_W'(upd_idx_i) < cnt_q;
  // on a simultaneous pull the push lands one slot lower, behind the shifted entries
  assign tgt     = pull_ok ? cnt_q - CNT_W'(1) : cnt_q;
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ent_d = '0;
      cnt_d = '0;
    end else begin
      if (pull_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
        ent_d[DEPTH-1] = '0;
      end
      if (upd_ok && !pull_ok) ent_d[upd_idx_i] = upd_value_i;
      if (upd_ok && pull_ok && upd_idx_i != '0) ent_d[upd_idx_i - IDX_W'(1)] = upd_value_i;
      if (push_ok) ent_d[tgt[IDX_W-1:0]] = push_value_i;
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pull_ok);
    end
    ovf_d = (!flush_i && push_i && !push_ok) || (ovf_q && !err_clr_i);
    unf_d = (!flush_i && pull_i && !pull_ok) || (unf_q && !err_clr_i);
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ent_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_comb begin
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) valid_o[i] = CNT_W'(i) < cnt_q;
  end
  assign vector_o     = ent_q;
  assign head_o       = ent_q[0];
  assign head_valid_o = cnt_q != '0;
  assign count_o      = cnt_q;
  assign full_o       = cnt_q == CNT_W'(DEPTH);
  assign empty_o      = cnt_q == '0;
  assign overflow_o   = ovf_q;
  assign underflow_o  = unf_q;
endmodule

// File: tb/tb_status_value_queue.sv
// tb_status_value_queue: directed plus random checks against a queue-based reference model
module tb_status_value_queue;
  localparam int W = 8, D = 4;
  logic clk_i = 0, arst_i = 1, flush_i = 0, push_i = 0, pull_i = 0, upd_i = 0, err_clr_i = 0;
  logic [W-1:0] push_value_i = 0, upd_value_i = 0;
  logic [1:0] upd_idx_i = 0;
  logic [W-1:0] head_o;
  logic head_valid_o, full_o, empty_o, overflow_o, underflow_o;
  logic [D*W-1:0] vector_o;
  logic [D-1:0] valid_o;
  logic [2:0] count_o;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  bit m_ovf = 0, m_unf = 0;

  status_value_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .flush_i(flush_i), .push_i(push_i), .push_value_i(push_value_i),
    .pull_i(pull_i), .upd_i(upd_i), .upd_idx_i(upd_idx_i), .upd_value_i(upd_value_i),
    .err_clr_i(err_clr_i), .head_o(head_o), .head_valid_o(head_valid_o), .vector_o(vector_o),
    .valid_o(valid_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] ev = '0;
    for (int i = 0; i < q.size(); i++) ev[i*W +: W] = q[i];
    chk("count", 32'(count_o), 32'(q.size()));
    chk("vector", vector_o, ev);
    chk("valid", 32'(valid_o), (32'd1 << q.size()) - 1);
    chk("full", 32'(full_o), 32'(q.size() == D));
    chk("empty", 32'(empty_o), 32'(q.size() == 0));
    chk("head_valid", 32'(head_valid_o), 32'(q.size() != 0));
    chk("head", 32'(head_o), q.size() ? 32'(q[0]) : 32'd0);
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("underflow", 32'(underflow_o), 32'(m_unf));
  endtask

  task automatic cycle(input bit fl, input bit ps, input logic [W-1:0] pv, input bit pl,
                       input bit up, input int ui, input logic [W-1:0] uv, input bit cl);
    bit pull_ok, push_ok;
    flush_i = fl; push_i = ps; push_value_i = pv; pull_i = pl;
    upd_i = up; upd_idx_i = 2'(ui); upd_value_i = uv; err_clr_i = cl;
    @(posedge clk_i);
    pull_ok = pl && q.size() > 0;
    push_ok = ps && (q.size() < D || pull_ok);
    if (fl) q.delete();
    else begin
      if (up && ui < q.size()) q[ui] = uv;
      if (pull_ok) void'(q.pop_front());
      if (push_ok) q.push_back(pv);
    end
    m_ovf = (!fl && ps && !push_ok) || (m_ovf && !cl);
    m_unf = (!fl && pl && !pull_ok) || (m_unf && !cl);
    #1;
    {flush_i, push_i, pull_i, upd_i, err_clr_i} = '0;
    check_all();
  endtask

  task automatic do_reset();
    arst_i = 1;
    #1;
    q.delete(); m_ovf = 0; m_unf = 0;
    check_all();
    @(posedge clk_i); #1;
    arst_i = 0;
  endtask

  initial begin
    do_reset();
    foreach (q[i]) ;
    cycle(0,1,8'h11,0,0,0,0,0); cycle(0,1,8'h22,0,0,0,0,0);
    cycle(0,1,8'h33,0,0,0,0,0); cycle(0,1,8'h44,0,0,0,0,0);
    chk("fill_vec", vector_o, 32'h44332211);
    chk("fill_full", 32'(full_o), 32'd1);
    cycle(0,1,8'h55,0,0,0,0,0);
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("ovf_vec", vector_o, 32'h44332211);
    cycle(0,0,0,0,0,0,0,1);
    chk("ovf_clr", 32'(overflow_o), 32'd0);
    cycle(0,1,8'h55,1,0,0,0,0);
    chk("pp_full_vec", vector_o, 32'h55443322);
    chk("pp_full_cnt", 32'(count_o), 32'd4);
    do_reset();
    cycle(0,1,8'h11,0,0,0,0,0); cycle(0,1,8'h22,0,0,0,0,0); cycle(0,1,8'h33,0,0,0,0,0);
    cycle(0,0,0,1,1,2,8'hAA,0);
    chk("upd_pull_vec", vector_o, 32'h0000AA22);
    chk("upd_pull_cnt", 32'(count_o), 32'd2);
    cycle(0,0,0,0,1,3,8'hBB,0);
    chk("upd_oob_vec", vector_o, 32'h0000AA22);
    cycle(0,0,0,1,1,0,8'hCC,0);
    chk("upd_drop_vec", vector_o, 32'h000000AA);
    cycle(1,0,0,0,0,0,0,0);
    cycle(0,1,8'h77,1,0,0,0,0);
    chk("empty_pp_head", 32'(head_o), 32'h77);
    chk("empty_pp_unf", 32'(underflow_o), 32'd1);
    cycle(1,1,8'h99,0,0,0,0,0);
    chk("flush_empty", 32'(empty_o), 32'd1);
    chk("flush_unf", 32'(underflow_o), 32'd1);
    cycle(0,0,0,1,0,0,0,1);
    chk("set_beats_clr", 32'(underflow_o), 32'd1);
    cycle(0,1,8'h01,0,0,0,0,0); cycle(0,1,8'h02,0,0,0,0,0);
    @(negedge clk_i);
    do_reset();
    chk("arst_empty", 32'(empty_o), 32'd1);
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0,24) == 0, $urandom_range(0,1), 8'($urandom), $urandom_range(0,1),
            $urandom_range(0,2) == 0, $urandom_range(0,3), 8'($urandom), $urandom_range(0,9) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
